aes_result_fifo: RTL and testbench

Output buffer and word serializer directly downstream of the AES last-round stage. Each cycle it samples the 130-bit `out_packet_t` produced by the last round, stores valid packets in a small FIFO, and drains them to the host bus as four 32-bit beats per block under a valid/ready handshake. The last-round pipeline cannot stall, so this block absorbs bursts, gives the issue logic an early throttle signal, and flags any loss.

---
 rtl/aes_result_fifo.sv | 165 ++++++++++++++++
 tb/tb_aes_result_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_fifo.sv
// aes_result_fifo
//
// Output buffer and 4-beat word serializer behind the AES last-round stage.
// Valid packets from the last round are queued in a DEPTH-entry FIFO. A
// serializer register then drains them to the host as four 32-bit beats
// (most-significant word first) under a valid/ready handshake. The last-round
// pipeline cannot stall, so this block does three things:
//   - it absorbs bursts,
//   - it raises almost_full early so the issue logic can throttle,
//   - it sets a sticky overflow flag when a packet has to be dropped.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   data_in      : {valid[129], data[128:1], en_de[0]} sampled every cycle
//   out_valid    : a beat is presented on out_word
//   out_ready    : host accepts the current beat
//   out_word     : current 32-bit beat
//   out_last     : high on the fourth beat of a block
//   out_en_de    : en_de of the block being sent (1 = decrypt)
//   count        : FIFO occupancy (serializer register not included)
//   almost_full  : count >= AFULL_LEVEL
//   overflow     : sticky, a valid packet was dropped
//   clr_overflow : clears overflow (a drop in the same cycle wins)
module aes_result_fifo #(
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [129:0]             data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_word,
    output logic                     out_last,
    output logic                     out_en_de,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    typedef enum logic {IDLE, SEND} state_t;

    // Each FIFO entry holds {data[127:0], en_de}.
    logic [128:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;

    state_t         state_q;
    logic [127:0]   shreg_q;
    logic           en_de_q;
    logic [1:0]     beat_q;

    logic           in_valid;
    logic           handshake;
    logic           pop;
    logic           push;
    logic           drop;
    logic [128:0]   head;

    assign in_valid  = data_in[129];
    assign head      = mem_q[rd_ptr_q];
    assign handshake = (state_q == SEND) && out_ready;

    // A pop happens either on an IDLE load or on a reload after the final
    // beat. Both use the registered count, so a push into an empty FIFO is
    // only visible to the serializer one cycle later.
    assign pop  = (count_q != '0) &&
                  ((state_q == IDLE) || (handshake && beat_q == 2'd3));
    // A full FIFO still accepts a packet when an entry leaves in the same cycle.
    assign push = in_valid && ((count_q != DEPTH_C) || pop);
    assign drop = in_valid && !push;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control: pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in[128:0];
        end
    end

    // Serializer FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            en_de_q <= 1'b0;
            beat_q  <= 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shreg_q <= head[128:1];
                        en_de_q <= head[0];
                        beat_q  <= 2'd0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (beat_q != 2'd3) begin
                            shreg_q <= {shreg_q[95:0], 32'h0};
                            beat_q  <= beat_q + 2'd1;
                        end else if (pop) begin
                            // Back-to-back reload: the next block starts without a bubble.
                            shreg_q <= head[128:1];
                            en_de_q <= head[0];
                            beat_q  <= 2'd0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid   = (state_q == SEND);
    assign out_word    = shreg_q[127:96];
    assign out_last    = (state_q == SEND) && (beat_q == 2'd3);
    assign out_en_de   = en_de_q;
    assign count       = count_q;
    assign almost_full = (count_q >= AFULL_C);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_aes_result_fifo.sv
module tb_aes_result_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic [129:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_word;
    logic         out_last;
    logic         out_en_de;
    logic [2:0]   count;
    logic         almost_full;
    logic         overflow;
    logic         clr_overflow;

    int checks = 0;
    int errors = 0;

    aes_result_fifo #(.DEPTH(4), .AFULL_LEVEL(3)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word(out_word),
        .out_last(out_last),
        .out_en_de(out_en_de),
        .count(count),
        .almost_full(almost_full),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Words of the reference block used in the single/backpressure tests.
    logic [31:0] ref_w [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

    // Packet p carries words A000_pp0i and en_de = p odd.
    function automatic logic [31:0] wd(int p, int i);
        return 32'hA000_0000 | 32'(p << 8) | 32'(i);
    endfunction

    function automatic logic [129:0] pkt(int p);
        return {1'b1, wd(p, 0), wd(p, 1), wd(p, 2), wd(p, 3), 1'(p % 2)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; data_in = '0; out_ready = 1'b0; clr_overflow = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rst_word: got %h expected 0", out_word); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b expected 0", out_last); end
        checks++; if (out_en_de !== 1'b0) begin errors++; $display("FAIL rst_en_de: got %b expected 0", out_en_de); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b expected 0", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        data_in = {1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
        tick();
        data_in = '0;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_written: got %0d expected 1", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b expected 0", out_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid beat %0d: got %b expected 1", i, out_valid); end
            checks++; if (out_word !== ref_w[i]) begin errors++; $display("FAIL single_word beat %0d: got %h expected %h", i, out_word, ref_w[i]); end
            checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL single_last beat %0d: got %b expected %b", i, out_last, (i == 3)); end
            checks++; if (out_en_de !== 1'b0) begin errors++; $display("FAIL single_en_de beat %0d: got %b expected 0", i, out_en_de); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_invalid_filter;
        data_in = 130'hdeadbeef;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL invalid_count cycle %0d: got %0d expected 0", c, count); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL invalid_valid cycle %0d: got %b expected 0", c, out_valid); end
        end
        data_in = '0;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        data_in = {1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0};
        tick();
        data_in = '0;
        tick();
        checks++; if (out_word !== ref_w[0]) begin errors++; $display("FAIL bp_beat0: got %h expected %h", out_word, ref_w[0]); end
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d: got %b expected 1", c, out_valid); end
            checks++; if (out_word !== ref_w[1]) begin errors++; $display("FAIL bp_hold_word cycle %0d: got %h expected %h", c, out_word, ref_w[1]); end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_word !== ref_w[i]) begin errors++; $display("FAIL bp_resume beat %0d: got %h expected %h", i, out_word, ref_w[i]); end
            checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL bp_last beat %0d: got %b expected %b", i, out_last, (i == 3)); end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_fill_overflow;
        out_ready = 1'b0;
        for (int p = 1; p <= 6; p++) begin
            data_in = pkt(p);
            tick();
        end
        data_in = '0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL fill_afull: got %b expected 1", almost_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b expected 1", overflow); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clr: got %b expected 0", overflow); end
        out_ready = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid p%0d b%0d: got %b expected 1", p, i, out_valid); end
                checks++; if (out_word !== wd(p, i)) begin errors++; $display("FAIL drain_word p%0d b%0d: got %h expected %h", p, i, out_word, wd(p, i)); end
                checks++; if (out_last !== (i == 3)) begin errors++; $display("FAIL drain_last p%0d b%0d: got %b expected %b", p, i, out_last, (i == 3)); end
                checks++; if (out_en_de !== 1'(p % 2)) begin errors++; $display("FAIL drain_en_de p%0d b%0d: got %b expected %b", p, i, out_en_de, 1'(p % 2)); end
                tick();
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_end: got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_push_on_full;
        out_ready = 1'b0;
        for (int p = 1; p <= 5; p++) begin
            data_in = pkt(p);
            tick();
        end
        data_in = '0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pof_count_full: got %0d expected 4", count); end
        out_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL pof_last_beat: got %b expected 1", out_last); end
        data_in = pkt(6);
        tick();
        data_in = '0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL pof_count: got %0d expected 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pof_ovf: got %b expected 0", overflow); end
        for (int p = 2; p <= 6; p++) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pof_valid p%0d b%0d: got %b expected 1", p, i, out_valid); end
                checks++; if (out_word !== wd(p, i)) begin errors++; $display("FAIL pof_word p%0d b%0d: got %h expected %h", p, i, out_word, wd(p, i)); end
                tick();
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pof_valid_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int p = 1; p <= 4; p++) begin
            data_in = pkt(p);
            tick();
        end
        data_in = '0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rm_count_queued: got %0d expected 3", count); end
        out_ready = 1'b1;
        tick(); tick();
        checks++; if (out_word !== wd(1, 2)) begin errors++; $display("FAIL rm_beat2: got %h expected %h", out_word, wd(1, 2)); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
        checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL rm_word: got %h expected 0", out_word); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rm_last: got %b expected 0", out_last); end
        checks++; if (out_en_de !== 1'b0) begin errors++; $display("FAIL rm_en_de: got %b expected 0", out_en_de); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rm_afull: got %b expected 0", almost_full); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_after: got %b expected 0", out_valid); end
        data_in = {1'b1, 128'h00112233445566778899aabbccddeeff, 1'b1};
        tick();
        data_in = '0;
        tick();
        checks++; if (out_en_de !== 1'b1) begin errors++; $display("FAIL rm_new_en_de: got %b expected 1", out_en_de); end
        checks++; if (out_word !== 32'h00112233) begin errors++; $display("FAIL rm_new_w0: got %h expected 00112233", out_word); end
        tick(); tick(); tick();
        checks++; if (out_word !== 32'hccddeeff) begin errors++; $display("FAIL rm_new_w3: got %h expected ccddeeff", out_word); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rm_new_last: got %b expected 1", out_last); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_new_alone: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_invalid_filter();
        test_backpressure();
        test_fill_overflow();
        test_push_on_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
